// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Pixel stream handshake between the upstream pixel FIFO and the
//             VGA timing generator.
//  Signals  : pix_data  [23:0] upstream pixel {R,G,B}
//             pix_valid        upstream pixel available
//             pix_ready        pixel consumed this cycle (from the generator)
//  Modports : master - pixel source (FIFO side)
//             slave  - pixel sink   (timing generator side)
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Video timing generator and pixel output stage. Produces HS/VS,
//             BLANK and registered RGB; in the active area pixels come either
//             from the upstream stream or from a built-in grid pattern.
//  Ports    : pixel_clk      pixel clock (only clock)
//             pixel_rst      asynchronous active-high reset
//             pattern_en     1 = grid test pattern, 0 = upstream stream
//             pix            pixel stream handshake (slave side)
//             frame_start    one-cycle pulse at frame origin
//             VGA_HS/VGA_VS  syncs, active low
//             VGA_BLANK      1 in the active area
//             VGA_R/G/B      pixel colour
//             underflow      sticky missing-pixel flag
//             underflow_cnt  saturating count of missing pixels
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int HDISP  = 800,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VDISP  = 480,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  wire               pixel_clk,
    input  wire               pixel_rst,
    input  wire               pattern_en,
    vga_timing_gen_if.slave   pix,
    output logic              frame_start,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              underflow,
    output logic [15:0]       underflow_cnt
);

    localparam int c_HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int c_VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int c_HW     = $clog2(c_HTOTAL);
    localparam int c_VW     = $clog2(c_VTOTAL);

    localparam logic [c_HW-1:0] c_HLAST   = c_HW'(c_HTOTAL - 1);
    localparam logic [c_VW-1:0] c_VLAST   = c_VW'(c_VTOTAL - 1);
    localparam logic [c_HW-1:0] c_HSTART  = c_HW'(c_HTOTAL - HDISP);
    localparam logic [c_VW-1:0] c_VSTART  = c_VW'(c_VTOTAL - VDISP);
    localparam logic [c_HW-1:0] c_HS_BEG  = c_HW'(HFP);
    localparam logic [c_HW-1:0] c_HS_END  = c_HW'(HFP + HPULSE);
    localparam logic [c_VW-1:0] c_VS_BEG  = c_VW'(VFP);
    localparam logic [c_VW-1:0] c_VS_END  = c_VW'(VFP + VPULSE);

    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;

    logic            r_hs;
    logic            r_vs;
    logic            r_blank;
    logic            r_fs;
    logic [23:0]     r_rgb;
    logic            r_uf;
    logic [15:0]     r_ucnt;

    logic            w_active;
    logic            w_hsync;
    logic            w_vsync;
    logic [3:0]      w_x_lo;
    logic [3:0]      w_y_lo;
    logic            w_grid;
    logic [23:0]     w_rgb;
    logic            w_miss;

    // ------------------------------------------------------------------
    // Pixel / line counters
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == c_HLAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == c_VLAST) ? '0 : r_vcnt + c_VW'(1);
        end else begin
            r_hcnt <= r_hcnt + c_HW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current counter state
    // ------------------------------------------------------------------
    assign w_active = (r_hcnt >= c_HSTART) && (r_vcnt >= c_VSTART);
    assign w_hsync  = (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END);
    assign w_vsync  = (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END);

    // Only the low nibble of the pixel coordinate matters for the grid, and
    // the subtraction is exact modulo 16, so it is done on 4 bits.
    assign w_x_lo   = r_hcnt[3:0] - c_HSTART[3:0];
    assign w_y_lo   = r_vcnt[3:0] - c_VSTART[3:0];
    assign w_grid   = (w_x_lo == 4'd0) || (w_y_lo == 4'd0);

    assign pix.pix_ready = w_active & ~pattern_en;

    always_comb begin
        w_rgb  = 24'h000000;
        w_miss = 1'b0;
        if (w_active) begin
            if (pattern_en) begin
                w_rgb = w_grid ? 24'hFFFFFF : 24'h000000;
            end else if (pix.pix_valid) begin
                w_rgb = pix.pix_data;
            end else begin
                w_miss = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: everything describes the counter state of the
    // previous cycle, so all pins stay mutually aligned.
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_blank <= 1'b0;
            r_fs    <= 1'b0;
            r_rgb   <= 24'h000000;
            r_uf    <= 1'b0;
            r_ucnt  <= 16'h0000;
        end else begin
            r_hs    <= ~w_hsync;
            r_vs    <= ~w_vsync;
            r_blank <= w_active;
            r_fs    <= (r_hcnt == '0) && (r_vcnt == '0);
            r_rgb   <= w_rgb;
            if (w_miss) begin
                r_uf <= 1'b1;
                if (r_ucnt != 16'hFFFF) begin
                    r_ucnt <= r_ucnt + 16'd1;
                end
            end
        end
    end

    assign frame_start   = r_fs;
    assign VGA_HS        = r_hs;
    assign VGA_VS        = r_vs;
    assign VGA_BLANK     = r_blank;
    assign VGA_R         = r_rgb[23:16];
    assign VGA_G         = r_rgb[15:8];
    assign VGA_B         = r_rgb[7:0];
    assign underflow     = r_uf;
    assign underflow_cnt = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. A reduced-size timing
//             instance is compared every cycle against an arithmetic model of
//             the frame; a second high-duty instance exercises counter
//             saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    // main instance geometry
    localparam int HD = 60, HF = 3, HP = 4, HB = 5;
    localparam int VD = 36, VF = 2, VP = 3, VB = 4;
    localparam int HT = HF + HP + HB + HD;   // 72
    localparam int VT = VF + VP + VB + VD;   // 45
    localparam int FR = HT * VT;             // 3240

    // saturation instance geometry (mostly active)
    localparam int SHD = 125, SVD = 61;
    localparam int SHT = SHD + 3, SVT = SVD + 3;
    localparam int SFR = SHT * SVT;          // 8192
    localparam int SACT = SHD * SVD;         // 7625

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic        rst = 1'b0;
    logic        pat;
    logic        d_fs, d_hs, d_vs, d_blank, d_uf;
    logic [7:0]  d_r, d_g, d_b;
    logic [15:0] d_cnt;
    vga_timing_gen_if m_if ();

    vga_timing_gen #(
        .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
        .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)
    ) u_dut (
        .pixel_clk    (clk),
        .pixel_rst    (rst),
        .pattern_en   (pat),
        .pix          (m_if),
        .frame_start  (d_fs),
        .VGA_HS       (d_hs),
        .VGA_VS       (d_vs),
        .VGA_BLANK    (d_blank),
        .VGA_R        (d_r),
        .VGA_G        (d_g),
        .VGA_B        (d_b),
        .underflow    (d_uf),
        .underflow_cnt(d_cnt)
    );

    // ---------------- saturation DUT ----------------
    logic        s_rst = 1'b0;
    logic        s_pat = 1'b0;
    logic        s_fs, s_hs, s_vs, s_blank, s_uf;
    logic [7:0]  s_r, s_g, s_b;
    logic [15:0] s_cnt;
    vga_timing_gen_if s_if ();

    vga_timing_gen #(
        .HDISP(SHD), .HFP(1), .HPULSE(1), .HBP(1),
        .VDISP(SVD), .VFP(1), .VPULSE(1), .VBP(1)
    ) u_sat (
        .pixel_clk    (clk),
        .pixel_rst    (s_rst),
        .pattern_en   (s_pat),
        .pix          (s_if),
        .frame_start  (s_fs),
        .VGA_HS       (s_hs),
        .VGA_VS       (s_vs),
        .VGA_BLANK    (s_blank),
        .VGA_R        (s_r),
        .VGA_G        (s_g),
        .VGA_B        (s_b),
        .underflow    (s_uf),
        .underflow_cnt(s_cnt)
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;
    bit sat_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack(input logic hs, input logic vs, input logic bl,
                                         input logic fs, input logic [23:0] rgb,
                                         input logic uf, input logic [15:0] cnt);
        return {19'd0, hs, vs, bl, fs, rgb, uf, cnt};
    endfunction

    // ---------------- reference model state ----------------
    int          p;        // frame position of the counter state about to be registered
    bit          m_uf;
    logic [15:0] m_ucnt;
    logic [63:0] last_o;
    int n_hs_low, n_vs_low, n_blank, n_fs, n_xfer;

    function automatic bit is_act(input int q);
        return ((q % HT) >= HT - HD) && ((q / HT) >= VT - VD);
    endfunction

    task automatic clr_stats();
        n_hs_low = 0; n_vs_low = 0; n_blank = 0; n_fs = 0; n_xfer = 0;
    endtask

    // One pixel cycle: called and returns at a falling edge.
    task automatic step(input bit pt, input bit vld, input logic [23:0] dat);
        int h, v;
        bit act;
        logic [23:0] rgb;
        logic [63:0] e, o;
        pat = pt;
        m_if.pix_valid = vld;
        m_if.pix_data  = dat;
        h   = p % HT;
        v   = p / HT;
        act = is_act(p);
        #1;
        chk("ready", m_if.pix_ready, act && !pt);
        if (m_if.pix_ready && vld) n_xfer++;
        rgb = 24'h0;
        if (act) begin
            if (pt) begin
                rgb = (((h - (HT - HD)) % 16 == 0) || ((v - (VT - VD)) % 16 == 0)) ? 24'hFFFFFF : 24'h0;
            end else if (vld) begin
                rgb = dat;
            end else begin
                m_uf = 1'b1;
                if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
            end
        end
        e = pack(!(h >= HF && h < HF + HP), !(v >= VF && v < VF + VP), act, p == 0,
                 rgb, m_uf, m_ucnt);
        @(posedge clk);
        #1;
        o = pack(d_hs, d_vs, d_blank, d_fs, {d_r, d_g, d_b}, d_uf, d_cnt);
        chk("vid", o, e);
        last_o = o;
        if (!d_hs)   n_hs_low++;
        if (!d_vs)   n_vs_low++;
        if (d_blank) n_blank++;
        if (d_fs)    n_fs++;
        p = (p + 1) % FR;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_seq
        logic [23:0] dat;
        logic [23:0] first_rgb, last_rgb;
        bit seen, a, vld;
        int n, n_black;

        pat = 1'b0;
        m_if.pix_valid = 1'b0;
        m_if.pix_data  = 24'h0;
        p = 0; m_uf = 1'b0; m_ucnt = 16'h0;

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_vid", pack(d_hs, d_vs, d_blank, d_fs, {d_r, d_g, d_b}, d_uf, d_cnt),
            pack(1, 1, 0, 0, 24'h0, 0, 16'h0));
        chk("rst_rdy", m_if.pix_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", pack(d_hs, d_vs, d_blank, d_fs, {d_r, d_g, d_b}, d_uf, d_cnt),
            pack(1, 1, 0, 0, 24'h0, 0, 16'h0));
        @(negedge clk);
        rst = 1'b0;

        // pattern mode, one frame
        clr_stats();
        for (int i = 0; i < FR; i++) step(1'b1, 1'($urandom), 24'($urandom));
        chk("pat_fs",    n_fs, 1);
        chk("pat_hs",    n_hs_low, VT * HP);
        chk("pat_vs",    n_vs_low, VP * HT);
        chk("pat_blank", n_blank, HD * VD);
        chk("pat_xfer",  n_xfer, 0);

        // stream mode, always valid, incrementing data
        clr_stats();
        dat = 24'h0; seen = 1'b0; first_rgb = 24'h0; last_rgb = 24'h0;
        for (int i = 0; i < FR; i++) begin
            a = is_act(p);
            step(1'b0, 1'b1, dat);
            if (a) begin
                if (!seen) first_rgb = last_o[40:17];
                seen = 1'b1;
                last_rgb = last_o[40:17];
                dat = dat + 24'd1;
            end
        end
        chk("str_xfer",  n_xfer, HD * VD);
        chk("str_first", first_rgb, 24'h0);
        chk("str_last",  last_rgb, HD * VD - 1);
        chk("str_uf",    d_uf, 0);
        chk("str_fs",    n_fs, 1);

        // stream mode with 10 missing active pixels
        n = 0; n_black = 0;
        for (int i = 0; i < FR; i++) begin
            a = is_act(p);
            vld = !(a && n >= 100 && n < 110);
            step(1'b0, vld, dat);
            if (a) begin
                if (vld) dat = dat + 24'd1;
                else if (last_o[40:17] == 24'h0) n_black++;
                n++;
            end
        end
        chk("drop_black", n_black, 10);
        chk("drop_cnt",   d_cnt, 16'd10);
        chk("drop_uf",    d_uf, 1);

        // random mode switching and gaps
        begin
            bit pm = 1'b0;
            for (int i = 0; i < FR; i++) begin
                if ($urandom_range(0, 63) == 0) pm = ~pm;
                step(pm, $urandom_range(0, 7) != 0, 24'($urandom));
            end
        end

        // run to mid-line then reset asynchronously
        for (int i = 0; i < FR && p != 20 * HT + 50; i++)
            step(1'b0, $urandom_range(0, 7) != 0, 24'($urandom));
        chk("mid_pos", p, 20 * HT + 50);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vid", pack(d_hs, d_vs, d_blank, d_fs, {d_r, d_g, d_b}, d_uf, d_cnt),
            pack(1, 1, 0, 0, 24'h0, 0, 16'h0));
        chk("mid_rst_rdy", m_if.pix_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        p = 0; m_uf = 1'b0; m_ucnt = 16'h0;

        clr_stats();
        for (int i = 0; i < FR; i++) step(1'b0, $urandom_range(0, 3) != 0, 24'($urandom));
        chk("post_fs",    n_fs, 1);
        chk("post_hs",    n_hs_low, VT * HP);
        chk("post_vs",    n_vs_low, VP * HT);
        chk("post_blank", n_blank, HD * VD);

        // wait for the saturation run, bounded
        for (int i = 0; i < 100000 && !sat_done; i++) @(posedge clk);
        chk("sat_done", sat_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // ---------------- saturation sequence ----------------
    initial begin : sat_seq
        s_if.pix_valid = 1'b0;
        s_if.pix_data  = 24'h0;
        #2 s_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s_rst = 1'b0;
        repeat (SFR) @(posedge clk);
        @(negedge clk);
        chk("sat_f1", s_cnt, SACT);
        repeat (7 * SFR) @(posedge clk);
        @(negedge clk);
        chk("sat_f8", s_cnt, 8 * SACT);
        repeat (SFR) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", s_cnt, 16'hFFFF);
        chk("sat_uf",  s_uf, 1);
        sat_done = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Video timing generator and pixel output stage for the 800x480 TFT panel, clocked by the 32 MHz `pixel_clk`. It produces horizontal and vertical sync, the blanking signal and registered 24-bit RGB from the PLL's pixel clock. In the active area it either pulls pixels from an upstream stream (the pixel FIFO fed from SDRAM over Wishbone) or generates a built-in grid test pattern. It sits between that FIFO and the video pins of the hardware-support interface.

## Interface
- `HDISP`, 800, active pixels per line
- `HFP`, 40, horizontal front porch (cycles)
- `HPULSE`, 48, horizontal sync pulse width
- `HBP`, 40, horizontal back porch
- `VDISP`, 480, active lines per frame
- `VFP`, 13, vertical front porch (lines)
- `VPULSE`, 3, vertical sync pulse width
- `VBP`, 29, vertical back porch
- `pixel_clk`  in  1  pixel clock; the only clock
- `pixel_rst`  in  1  reset, asynchronous, active-high
- `pattern_en`  in  1  1 = grid test pattern, 0 = upstream stream
- `pix_data`  in  24  upstream pixel, {R[7:0],G[7:0],B[7:0]}
- `pix_valid`  in  1  upstream pixel available
- `pix_ready`  out  1  pixel consumed this cycle
- `frame_start`  out  1  one-cycle pulse at frame origin
- `VGA_HS`  out  1  horizontal sync, active low
- `VGA_VS`  out  1  vertical sync, active low
- `VGA_BLANK`  out  1  1 in the active area, 0 in blanking
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  pixel colour
- `underflow`  out  1  sticky: an active pixel was missing
- `underflow_cnt`  out  16  saturating count of missing pixels

## Operation
- Derived values: HTOTAL = HFP+HPULSE+HBP+HDISP (928); VTOTAL = VFP+VPULSE+VBP+VDISP (525); HSTART = HTOTAL−HDISP; VSTART = VTOTAL−VDISP.
- Counters:
  - `hcnt` runs 0..HTOTAL−1 and wraps to 0.
  - `vcnt` increments when `hcnt` wraps; it runs 0..VTOTAL−1 and wraps to 0.
  - Counter widths are $clog2(total).
- Line layout, in `hcnt` order: front porch [0, HFP), sync [HFP, HFP+HPULSE), back porch, then active [HSTART, HTOTAL). The vertical layout uses the same order on `vcnt`.
- The active area is `hcnt` ≥ HSTART and `vcnt` ≥ VSTART. Pixel coordinates are x = hcnt−HSTART and y = vcnt−VSTART.
- `pix_ready` is combinational: active area AND `pattern_en`=0. A transfer occurs when `pix_ready` & `pix_valid`.
- Stream mode:
  - On a transfer, RGB = `pix_data`.
  - When active and `pix_valid`=0, RGB = 0x000000, `underflow` is set and `underflow_cnt` increments, saturating at 0xFFFF.
- Pattern mode: RGB = 0xFFFFFF when x[3:0]==0 or y[3:0]==0, otherwise 0x000000. No data is consumed.
- Outside the active area, RGB = 0x000000.
- `pattern_en` is sampled every cycle. A change takes effect on the next pixel with no realignment.
- `underflow` and `underflow_cnt` are cleared only by reset.

## Timing
- All outputs except `pix_ready` are registered. Pins lag the counters by exactly 1 cycle: HS, VS, BLANK, RGB and `frame_start` for counter state (h,v) appear together on the following clock edge, so they are mutually aligned.
- `frame_start` is high for 1 cycle, the output cycle of (hcnt=0, vcnt=0). Upstream uses it to resynchronise its read pointer.
- Periods:
  - HS: low for HPULSE cycles every HTOTAL cycles.
  - VS: low for VPULSE full lines every VTOTAL lines. VS edges coincide with the HS-period boundary (output of hcnt=0).
- `underflow` sets and `underflow_cnt` updates on the same output cycle as the black pixel.
- Reset (asynchronous, any time, including mid-line):
  - `hcnt` = `vcnt` = 0.
  - `VGA_HS` = `VGA_VS` = 1, `VGA_BLANK` = 0, RGB = 0, `frame_start` = 0, `underflow` = 0, `underflow_cnt` = 0.
  - `pix_ready` = 0, because the counters are outside the active area.
- After reset release:
  - The first edge registers state (0,0), so `frame_start` pulses 1 cycle after release.
  - Counting restarts from the origin with no partial frame.
- Frame length is exactly HTOTAL×VTOTAL = 487200 cycles.

## Test plan
- Reset, then free-run in pattern mode:
  - `frame_start` pulses every 487200 cycles.
  - HS is low for 48 of every 928 cycles.
  - VS is low for 3×928 cycles.
  - BLANK is high for exactly 800×480 cycles per frame.
- Pattern content:
  - Pixel (0,0) is 0xFFFFFF; pixel (1,1) is 0x000000; pixel (16,5) is 0xFFFFFF; pixel (17,17) is 0x000000.
  - `pix_ready` is never 1.
- Stream mode, `pix_valid` always 1, `pix_data` incrementing from 0:
  - Exactly 384000 transfers per frame.
  - The first active RGB is 0x000000 and the last is 0x05DBFF.
  - `underflow` stays 0.
- Stream mode with `pix_valid` dropped for 10 active cycles:
  - Those 10 outputs are black.
  - `underflow_cnt` = 10 and `underflow` = 1.
- Saturation: hold `pix_valid`=0 for 1 frame → `underflow_cnt` = 0xFFFF, with no wrap to 0.
- Assert `pixel_rst` mid-line at hcnt≈500, vcnt≈200:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, `frame_start` appears after 1 cycle and the HS/VS periods are correct from the origin.
